// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, stop.
// Define UART_TX_TWO_STOP_EN for a two-cycle stop bit.
module uart_tx_frame #(
    parameter int frame_data = 8,
    parameter int bit_cnt_w  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [frame_data-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [bit_cnt_w-1:0] LAST_CNT = bit_cnt_w'(frame_data - 1);

    state_e                  state_q, state_d;
    logic [bit_cnt_w-1:0]    cnt_q, cnt_d;
    logic [frame_data-1:0]   data_q, data_d;
    logic                    par_q, par_d;
    logic                    pen_q, pen_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    last_stop;
    logic                    accept;
    logic                    bit_sel;

`ifdef UART_TX_TWO_STOP_EN
    // Set during the second stop cycle; only then may a new byte be taken.
    logic stop2_q, stop2_d;

    assign last_stop = (state_q == STOP) && stop2_q;
    assign stop2_d   = (state_q == STOP) && (state_d == STOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop2_q <= 1'b0;
        end else begin
            stop2_q <= stop2_d;
        end
    end
`else
    assign last_stop = (state_q == STOP);
`endif

    assign accept = data_valid && ((state_q == IDLE) || last_stop);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        par_d   = par_q;
        pen_d   = pen_q;
        if (accept) begin
            state_d = START;
            cnt_d   = '0;
            data_d  = p_data;
            pen_d   = par_en;
            par_d   = par_typ ? ~^p_data : ^p_data;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                START: begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
                DATA: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        cnt_d = cnt_q + bit_cnt_w'(1);
                    end
                end
                PARITY: begin
                    state_d = STOP;
                end
                STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                    state_d = stop2_q ? IDLE : STOP;
`else
                    state_d = IDLE;
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Data bit for the next cycle, selected by the next counter value.
    always_comb begin
        bit_sel = 1'b0;
        for (int i = 0; i < frame_data; i++) begin
            if (cnt_d == bit_cnt_w'(i)) begin
                bit_sel = data_d[i];
            end
        end
    end

    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = bit_sel;
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            pen_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            par_q   <= par_d;
            pen_q   <= pen_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: constant frame table, corner sequences and
// randomized frames against a queue-based frame model.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       tx_out;
    logic       busy;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_N = 2;
`else
    localparam int STOP_N = 1;
`endif

    uart_tx_frame #(.frame_data(8), .bit_cnt_w(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic        pt;
        logic [10:0] bits;
        int          len;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic build(input logic [7:0] d, input logic pe, input logic pt);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back(pt ? ~^d : ^d);
        for (int i = 0; i < STOP_N; i++) exp_q.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        step();
    endtask

    task automatic idle(input string n, input int cyc);
        for (int i = 0; i < cyc; i++) begin
            chk($sformatf("%s_idle_tx[%0d]", n, i), tx_out, 1'b1);
            chk($sformatf("%s_idle_busy[%0d]", n, i), busy, 1'b0);
            step();
        end
    endtask

    // Checks the frame in exp_q; optionally strobes at cycle sidx.
    task automatic check_bits(input string n, input int sidx,
                              input logic [7:0] sd, input logic spe,
                              input logic spt, input bit scramble);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_tx[%0d]", n, i), tx_out, exp_q[i]);
            chk($sformatf("%s_busy[%0d]", n, i), busy, 1'b1);
            if (i == sidx) begin
                p_data     = sd;
                par_en     = spe;
                par_typ    = spt;
                data_valid = 1'b1;
            end else if (scramble) begin
                p_data  = 8'($urandom);
                par_en  = 1'($urandom);
                par_typ = 1'($urandom);
            end
            step();
        end
    endtask

    initial begin
        logic [7:0] d, nd;
        logic pe, pt, npe, npt;
        int b2b, sidx, last;

        vt[0] = '{8'hA5, 1'b0, 1'b0, 11'h34A, 10};
        vt[1] = '{8'h03, 1'b1, 1'b0, 11'h406, 11};
        vt[2] = '{8'h03, 1'b1, 1'b1, 11'h606, 11};
        vt[3] = '{8'h07, 1'b1, 1'b0, 11'h60E, 11};
        vt[4] = '{8'hFF, 1'b1, 1'b1, 11'h7FE, 11};
        vt[5] = '{8'h00, 1'b0, 1'b0, 11'h200, 10};

        #2 rst = 1'b0;
        #1;
        chk("reset_tx", tx_out, 1'b1);
        chk("reset_busy", busy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        idle("post_reset", 5);

        for (int v = 0; v < 6; v++) begin
            exp_q.delete();
            for (int j = 0; j < vt[v].len; j++) exp_q.push_back(vt[v].bits[j]);
            for (int j = 1; j < STOP_N; j++) exp_q.push_back(1'b1);
            send(vt[v].d, vt[v].pe, vt[v].pt);
            check_bits($sformatf("vec%0d", v), -1, 8'h00, 1'b0, 1'b0, 1'b1);
            idle($sformatf("vec%0d", v), 2);
        end

        build(8'hA5, 1'b0, 1'b0);
        send(8'hA5, 1'b0, 1'b0);
        check_bits("b2b_a5", exp_q.size() - 1, 8'h3C, 1'b0, 1'b0, 1'b0);
        build(8'h3C, 1'b0, 1'b0);
        check_bits("b2b_3c", -1, 8'h00, 1'b0, 1'b0, 1'b0);
        idle("b2b", 2);

        build(8'hA5, 1'b0, 1'b0);
        send(8'hA5, 1'b0, 1'b0);
        check_bits("ign_a5", exp_q.size() - 2, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle("ign", 3);

        build(8'hA5, 1'b0, 1'b0);
        send(8'hA5, 1'b0, 1'b0);
        for (int i = 0; i <= 5; i++) begin
            chk($sformatf("rst_pre_tx[%0d]", i), tx_out, exp_q[i]);
            if (i < 5) step();
        end
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_tx", tx_out, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        #3 rst = 1'b1;
        step();
        idle("rst_after", 2);
        build(8'h5A, 1'b1, 1'b1);
        send(8'h5A, 1'b1, 1'b1);
        check_bits("rst_new", -1, 8'h00, 1'b0, 1'b0, 1'b1);
        idle("rst_new", 1);

        d  = 8'($urandom);
        pe = 1'($urandom);
        pt = 1'($urandom);
        build(d, pe, pt);
        send(d, pe, pt);
        for (int n = 0; n < 40; n++) begin
            nd   = 8'($urandom);
            npe  = 1'($urandom);
            npt  = 1'($urandom);
            b2b  = int'($urandom_range(0, 1));
            last = exp_q.size() - 1;
            if (b2b != 0) sidx = last;
            else if ($urandom_range(0, 1) != 0) sidx = int'($urandom_range(0, last - 1));
            else sidx = -1;
            check_bits($sformatf("rnd%0d", n), sidx, nd, npe, npt, 1'b1);
            build(nd, npe, npt);
            if (b2b == 0) begin
                idle($sformatf("rnd%0d", n), int'($urandom_range(1, 3)));
                send(nd, npe, npt);
            end
        end
        check_bits("rnd_last", -1, 8'h00, 1'b0, 1'b0, 1'b0);
        idle("end", 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
